// File: rtl/instruction_fetch.sv
// Byte-serial x86 subset instruction fetch: reads one byte at a time, decodes the length and presents the instruction.
// Optional macro FETCH_ILLEGAL_TRAP_EN: illegal opcode/ModRM halts fetch until reset or redirect.
module instruction_fetch #(
    parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [7:0]  mem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        ope_valid,
    input  logic        ope_ready,
    output logic [31:0] ope,
    output logic [3:0]  num_of_ope,
    output logic [31:0] eip,
    output logic        illegal
);

    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_PRESENT, ST_HALT} state_t;

    state_t      state, state_n;
    logic [31:0] eip_q, eip_n;
    logic [2:0]  k, k_n, k_inc;
    logic [31:0] ope_q, ope_n;
    logic [3:0]  num_q, num_n;
    logic        ill_q, ill_n;
    logic        drop, drop_n;

    logic [7:0]  b0, b1;
    logic [3:0]  base_len, len;
    logic        modrm, bad_op, mod10, decoded, done, ill;

    // Length decode sees the byte arriving this cycle as if it were already stored.
    always_comb begin
        b0       = (k == 3'd0) ? mem_data : ope_q[31:24];
        b1       = (k == 3'd1) ? mem_data : ope_q[23:16];
        k_inc    = k + 3'd1;
        modrm    = 1'b0;
        bad_op   = 1'b0;
        base_len = 4'd1;
        case (b0)
            8'h55, 8'h53, 8'h5d, 8'hc3, 8'hc9: base_len = 4'd1;
            8'h6a, 8'h75, 8'heb:               base_len = 4'd2;
            8'hb8, 8'he8:                      base_len = 4'd5;
            8'h89, 8'h8b: begin base_len = 4'd2; modrm = 1'b1; end
            8'h83:        begin base_len = 4'd3; modrm = 1'b1; end
            default:      begin base_len = 4'd1; bad_op = 1'b1; end
        endcase
        mod10   = modrm && (b1[7:6] == 2'b10);
        len     = base_len + {3'b000, modrm && (b1[7:6] == 2'b01)};
        decoded = !modrm || (k_inc >= 3'd2);
        done    = decoded && ({1'b0, k_inc} == len);
        ill     = bad_op || mod10;
    end

    always_comb begin
        state_n = state;
        eip_n   = eip_q;
        k_n     = k;
        ope_n   = ope_q;
        num_n   = num_q;
        ill_n   = ill_q;
        drop_n  = drop;
        mem_rd  = (state == ST_REQ) && !drop && !reset;

        if (drop && mem_valid)
            drop_n = 1'b0;

        if (redirect_valid) begin
            state_n = ST_REQ;
            eip_n   = redirect_addr;
            k_n     = 3'd0;
            ope_n   = 32'd0;
            num_n   = 4'd0;
            ill_n   = 1'b0;
            // A read issued now or still in flight must have its response swallowed.
            drop_n  = mem_rd || (((state == ST_WAIT) || drop) && !mem_valid);
        end else begin
            case (state)
                ST_REQ: if (mem_rd) state_n = ST_WAIT;
                ST_WAIT: if (mem_valid) begin
                    k_n = k_inc;
                    case (k)
                        3'd0:    ope_n[31:24] = mem_data;
                        3'd1:    ope_n[23:16] = mem_data;
                        3'd2:    ope_n[15:8]  = mem_data;
                        3'd3:    ope_n[7:0]   = mem_data;
                        default: ;
                    endcase
                    if (done) begin
                        state_n = ST_PRESENT;
                        num_n   = len;
                        ill_n   = ill;
`ifdef FETCH_ILLEGAL_TRAP_EN
                        if (ill) begin
                            state_n = ST_HALT;
                            num_n   = 4'd0;
                        end
`endif
                    end else begin
                        state_n = ST_REQ;
                    end
                end
                ST_PRESENT: if (ope_ready) begin
                    eip_n   = eip_q + {28'd0, num_q};
                    k_n     = 3'd0;
                    ope_n   = 32'd0;
                    num_n   = 4'd0;
                    ill_n   = 1'b0;
                    state_n = ST_REQ;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_REQ;
            eip_q <= RESET_EIP;
            k     <= 3'd0;
            ope_q <= 32'd0;
            num_q <= 4'd0;
            ill_q <= 1'b0;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            eip_q <= eip_n;
            k     <= k_n;
            ope_q <= ope_n;
            num_q <= num_n;
            ill_q <= ill_n;
            drop  <= drop_n;
        end
    end

    assign mem_addr   = eip_q + {29'd0, k};
    assign ope_valid  = (state == ST_PRESENT);
    assign ope        = ope_q;
    assign num_of_ope = num_q;
    assign eip        = eip_q;
    assign illegal    = ill_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed programs in a byte memory model, monitor checks each accepted instruction.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        ope_valid;
    logic        ope_ready = 1'b0;
    logic [31:0] ope;
    logic [3:0]  num_of_ope;
    logic [31:0] eip;
    logic        illegal;

    instruction_fetch dut (
        .clock(clock), .reset(reset),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .ope_valid(ope_valid), .ope_ready(ope_ready), .ope(ope),
        .num_of_ope(num_of_ope), .eip(eip), .illegal(illegal)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] ope;
        logic [3:0]  n;
        logic [31:0] eip;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [7:0]  mem [0:255];
    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [7:0]  paddr = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Memory: one response per mem_rd after lat cycles; reset discards anything in flight.
    always @(negedge clock) begin
        mem_valid = 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (cnt <= 1) begin
                    mem_valid = 1'b1;
                    mem_data  = mem[paddr];
                    pend      = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (mem_rd) begin
                check("single_outstanding", {31'd0, pend}, 32'd0);
                pend  = 1'b1;
                cnt   = lat;
                paddr = mem_addr[7:0];
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && ope_valid && ope_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ope: got ope=%h n=%0d eip=%h, none expected", ope, num_of_ope, eip);
            end else begin
                mon_e = exp_q.pop_front();
                check("ope", ope, mon_e.ope);
                check("num_of_ope", {28'd0, num_of_ope}, {28'd0, mon_e.n});
                check("eip", eip, mon_e.eip);
                check("illegal", {31'd0, illegal}, {31'd0, mon_e.ill});
            end
        end
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_ope(input logic [31:0] o, input logic [3:0] n, input logic [31:0] e, input logic il);
        exp_t x;
        x.ope = o; x.n = n; x.eip = e; x.ill = il;
        exp_q.push_back(x);
    endtask

    task automatic redirect_to(input logic [31:0] a);
        step();
        redirect_valid = 1'b1;
        redirect_addr  = a;
        step();
        redirect_valid = 1'b0;
        check("redirect_clears_valid", {31'd0, ope_valid}, 32'd0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_rd(input string name, input logic [31:0] a);
        int n = 0;
        @(negedge clock);
        while (!mem_rd && n < 50) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (!mem_rd || mem_addr !== a) begin
            fails++;
            $display("FAIL %s: got mem_rd=%b addr=%h, expected mem_rd=1 addr=%h", name, mem_rd, mem_addr, a);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clock);
        while (!ope_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check(name, {31'd0, ope_valid}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ope_valid"}, {31'd0, ope_valid}, 32'd0);
        check({tag, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
        check({tag, "_ope"}, ope, 32'd0);
        check({tag, "_num"}, {28'd0, num_of_ope}, 32'd0);
        check({tag, "_eip"}, eip, 32'd0);
        check({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h55;
        mem[8'h00] = 8'h55; mem[8'h01] = 8'h89; mem[8'h02] = 8'he5; mem[8'h03] = 8'hc3;
        mem[8'h10] = 8'he8; mem[8'h11] = 8'hee; mem[8'h12] = 8'hff; mem[8'h13] = 8'hff; mem[8'h14] = 8'hff;
        mem[8'h20] = 8'h83; mem[8'h21] = 8'h7d; mem[8'h22] = 8'hfc; mem[8'h23] = 8'h00;
        mem[8'h30] = 8'h6a; mem[8'h31] = 8'h05;
        mem[8'h40] = 8'h5d;
        mem[8'h50] = 8'h0f;
        mem[8'h60] = 8'h89; mem[8'h61] = 8'h85;
        mem[8'h70] = 8'h8b; mem[8'h71] = 8'h45; mem[8'h72] = 8'h08;
        mem[8'hff] = 8'hc3;

        repeat (2) step();
        check_reset_outputs("reset");

        // 55 89 e5 c3 with 1-cycle memory, plus minimum-latency timing
        expect_ope(32'h55000000, 4'd1, 32'h0, 1'b0);
        expect_ope(32'h89e50000, 4'd2, 32'h1, 1'b0);
        expect_ope(32'hc3000000, 4'd1, 32'h3, 1'b0);
        ope_ready = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        check("first_rd", {31'd0, mem_rd}, 32'd1);
        check("first_addr", mem_addr, 32'h0);
        @(negedge clock);
        check("lat_cycle1", {31'd0, ope_valid}, 32'd0);
        @(negedge clock);
        check("lat_cycle2", {31'd0, ope_valid}, 32'd1);
        drain(60);
        ope_ready = 1'b0;

        // 5-byte call, byte 4 discarded
        expect_ope(32'he8eeffff, 4'd5, 32'h10, 1'b0);
        redirect_to(32'h10);
        ope_ready = 1'b1;
        drain(60);
        ope_ready = 1'b0;
        wait_rd("next_after_call", 32'h15);

        // ModRM mod 01 with consumer stall
        redirect_to(32'h20);
        wait_valid("stall_valid");
        repeat (5) begin
            @(negedge clock);
            check("stall_ope", ope, 32'h837dfc00);
            check("stall_num", {28'd0, num_of_ope}, 32'd4);
            check("stall_eip", eip, 32'h20);
            check("stall_valid_held", {31'd0, ope_valid}, 32'd1);
            check("stall_no_rd", {31'd0, mem_rd}, 32'd0);
        end
        expect_ope(32'h837dfc00, 4'd4, 32'h20, 1'b0);
        step();
        ope_ready = 1'b1;
        drain(20);
        ope_ready = 1'b0;

        // Redirect while a slow read is outstanding
        lat = 3;
        redirect_to(32'h30);
        wait_rd("rd_30", 32'h30);
        redirect_to(32'h40);
        wait_rd("rd_after_redirect", 32'h40);
        expect_ope(32'h5d000000, 4'd1, 32'h40, 1'b0);
        ope_ready = 1'b1;
        drain(60);
        ope_ready = 1'b0;
        lat = 1;

        // eip wrap-around
        expect_ope(32'hc3000000, 4'd1, 32'hffffffff, 1'b0);
        redirect_to(32'hffffffff);
        ope_ready = 1'b1;
        drain(60);
        ope_ready = 1'b0;
        wait_rd("wrap_addr", 32'h0);

        // 8b with mod 01 displacement
        expect_ope(32'h8b450800, 4'd3, 32'h70, 1'b0);
        redirect_to(32'h70);
        ope_ready = 1'b1;
        drain(60);
        ope_ready = 1'b0;

`ifdef FETCH_ILLEGAL_TRAP_EN
        redirect_to(32'h50);
        repeat (4) step();
        check("halt_illegal", {31'd0, illegal}, 32'd1);
        check("halt_no_valid", {31'd0, ope_valid}, 32'd0);
        begin
            int rds = 0;
            repeat (10) begin
                @(negedge clock);
                if (mem_rd) rds++;
            end
            check("halt_no_rd", rds, 32'd0);
        end
        redirect_to(32'h60);
        check("halt_redirect_clears", {31'd0, illegal}, 32'd0);
        repeat (8) step();
        check("mod10_halt_illegal", {31'd0, illegal}, 32'd1);
        check("mod10_halt_no_valid", {31'd0, ope_valid}, 32'd0);
`else
        expect_ope(32'h0f000000, 4'd1, 32'h50, 1'b1);
        redirect_to(32'h50);
        ope_ready = 1'b1;
        drain(60);
        ope_ready = 1'b0;
        expect_ope(32'h89850000, 4'd2, 32'h60, 1'b1);
        redirect_to(32'h60);
        ope_ready = 1'b1;
        drain(60);
        ope_ready = 1'b0;
`endif

        // Reset in the middle of a 5-byte fetch
        redirect_to(32'h10);
        wait_rd("mid_rd0", 32'h10);
        wait_rd("mid_rd1", 32'h11);
        step();
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        step();
        step();
        expect_ope(32'h55000000, 4'd1, 32'h0, 1'b0);
        ope_ready = 1'b1;
        reset = 1'b0;
        wait_rd("restart_addr", 32'h0);
        drain(60);
        ope_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_EIP, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 clock  in  1  single system clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 mem_rd  out  1  one-cycle byte read request.
REQ-005 mem_addr  out  32  byte address, valid while mem_rd=1.
REQ-006 mem_valid  in  1  read data strobe, at least 1 cycle after mem_rd.
REQ-007 mem_data  in  8  read byte, valid while mem_valid=1.
REQ-008 redirect_valid  in  1  one-cycle request to restart fetch (jump/call/ret target).
REQ-009 redirect_addr  in  32  new fetch address, sampled with redirect_valid.
REQ-010 ope_valid  out  1  decoded instruction available.
REQ-011 ope_ready  in  1  consumer accepts ope this cycle.
REQ-012 ope  out  32  instruction bytes; byte 0 in [31:24], byte 1 in [23:16], byte 2 in [15:8], byte 3 in [7:0].
REQ-013 num_of_ope  out  4  instruction length in bytes, 1..5.
REQ-014 eip  out  32  address of byte 0 of the presented instruction.
REQ-015 illegal  out  1  unsupported opcode or ModRM form.

Function
REQ-016 States: REQ (drive mem_rd), WAIT (await mem_valid), PRESENT (ope_valid=1), HALT (only with the trap macro).
REQ-017 Only one read is outstanding at a time; mem_rd is asserted for exactly one cycle per byte, and the state moves REQ->WAIT on the same edge.
REQ-018 In WAIT, mem_valid stores mem_data into byte slot k (k<4) and increments k; bytes with k>=4 are consumed and discarded; the address advances to eip+k.
REQ-019 Length decode on byte 0, in hex:
- length 1: 55, 53, 5d, c3, c9.
- length 2: 6a, 75, eb.
- length 5: b8, e8.
- 89, 8b: 2 plus ModRM adjust.
- 83: 3 plus ModRM adjust.
REQ-020 ModRM adjust uses byte 1 mod=[7:6]: mod 00/11 add 0; mod 01 add 1; mod 10 is illegal.
REQ-021 Once k equals the length: state goes to PRESENT, unused ope slots are zero, and num_of_ope holds the length.
REQ-022 ope, num_of_ope, eip and illegal stay stable while ope_valid=1 and ope_ready=0.
REQ-023 Handshake on ope_valid&ope_ready:
- eip <= eip+num_of_ope (32-bit wrap-around, 32'hFFFF_FFFF+1 gives 0);
- k is cleared;
- state goes to REQ;
- ope_valid is low in the following cycle.
REQ-024 Minimum latency: mem_rd in cycle 0 and mem_valid in cycle 1 give ope_valid in cycle 2 for a 1-byte instruction. Each additional byte adds 2 cycles.
REQ-025 redirect_valid in any state has priority over the handshake and over mem_valid:
- eip <= redirect_addr, k cleared, ope_valid low next cycle, state goes to REQ.
- If a read is outstanding, the next mem_valid is dropped before the first new mem_rd is issued.
REQ-026 mem_valid outside WAIT, other than the dropped response, is ignored.

Reset
REQ-027 While reset is high: state=REQ, eip=RESET_EIP, k=0, ope=0, num_of_ope=0, ope_valid=0, mem_rd=0, illegal=0, drop flag=0.
REQ-028 The first mem_rd occurs in the first clock after reset deasserts.
REQ-029 Reset mid-fetch abandons the instruction; a response arriving after reset is ignored.

Configuration
REQ-030 Macro FETCH_ILLEGAL_TRAP_EN.
REQ-031 With FETCH_ILLEGAL_TRAP_EN defined, an illegal opcode or ModRM form:
- enters HALT with illegal=1, ope_valid=0 and no further mem_rd;
- HALT is left only by reset or redirect_valid, either of which clears illegal.
REQ-032 Without FETCH_ILLEGAL_TRAP_EN:
- an unknown opcode is presented as length 1 with illegal=1;
- ModRM mod 10 is presented with base length and illegal=1;
- HALT is unreachable.

Verification
REQ-033 Memory at 0 holds 55 89 e5 c3 with 1-cycle latency -> three instructions: (ope=55000000, n=1, eip=0), (ope=89e50000, n=2, eip=1), (ope=c3000000, n=1, eip=3).
REQ-034 Bytes e8 ee ff ff ff at 10 -> ope=e8eeffff, n=5, eip=10; the next fetch is at 15.
REQ-035 Bytes 83 7d fc 00 -> n=4, ope=837dfc00; ope_ready held low 5 cycles -> outputs stable and no mem_rd.
REQ-036 redirect_valid with redirect_addr=40 issued while WAIT with a 3-cycle latency -> late byte dropped; next mem_addr=40; the next instruction has eip=40.
REQ-037 Byte 0f:
- with FETCH_ILLEGAL_TRAP_EN -> illegal=1, no mem_rd for 10 cycles;
- without it -> ope=0f000000, n=1, illegal=1.
REQ-038 Reset asserted mid-way through a 5-byte fetch -> all outputs return to reset values immediately; fetch restarts at RESET_EIP.
